// File: rtl/nn_pixel_loader.sv
// nn_pixel_loader: streams one image into the nn_core pixel buffer, kicks the
// core, waits for its answer (with a timeout) and hands the predicted class to
// a downstream consumer. Malformed frame lengths and core timeouts are flagged
// through res_err instead of starting the core.
module nn_pixel_loader #(
    parameter int N_IN    = 784,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_pred,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_pred,
    output logic              res_err,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] LOAD   = 3'd0;
    localparam logic [2:0] DRAIN  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic [TW-1:0]     LAST_TICK = TW'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [TW-1:0]     tcnt;
    logic              accept;
    logic              load_accept;

    // The stream is open only while loading or draining; held closed during reset.
    assign s_ready     = rst && ((state == LOAD) || (state == DRAIN));
    assign accept      = s_valid && s_ready;
    assign load_accept = accept && (state == LOAD);
    assign busy        = !((state == LOAD) && (cnt == '0));

    // Pixel write port: every beat accepted in LOAD is written one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_we   <= 1'b0;
            pix_addr <= '0;
            pix_data <= '0;
        end else begin
            pix_we <= load_accept;
            if (load_accept) begin
                pix_addr <= cnt;
                pix_data <= s_data;
            end
        end
    end

    // Frame sequencing, core handshake, timeout and result hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            cnt        <= '0;
            tcnt       <= '0;
            core_start <= 1'b0;
            res_valid  <= 1'b0;
            res_pred   <= '0;
            res_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        // The counter parks at the last address so pix_addr never wraps.
                        if (cnt == LAST_ADDR) begin
                            state <= s_last ? START : DRAIN;
                        end else if (s_last) begin
                            state     <= RESULT;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_pred  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_pred  <= '0;
                    end
                end
                START: begin
                    core_start <= 1'b1;
                    tcnt       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last timeout tick still counts as success.
                    if (core_done) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b0;
                        res_pred  <= core_pred;
                    end else if (tcnt == LAST_TICK) begin
                        state     <= RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_pred  <= 4'hF;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state     <= LOAD;
                        res_valid <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_pixel_loader.sv
// Testbench for nn_pixel_loader: randomized frames against a frame-level
// reference model, with scoreboard queues consumed by an output monitor.
module tb_nn_pixel_loader;

    localparam int N_IN    = 784;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = '0;
    logic              s_last = 1'b0;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic              core_start;
    logic              core_done = 1'b0;
    logic [3:0]        core_pred = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [3:0]        res_pred;
    logic              res_err;
    logic              busy;

    nn_pixel_loader #(.N_IN(N_IN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
        .core_start(core_start), .core_done(core_done), .core_pred(core_pred),
        .res_valid(res_valid), .res_ready(res_ready), .res_pred(res_pred),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W+7:0] wr_q[$];
    logic [4:0]        res_q[$];
    int exp_start = -1;
    int exp_rise = -1;
    int starts = 0;
    int exp_starts = 0;
    int handshakes = 0;

    int         core_delay = 2;
    logic [3:0] core_pred_val = 4'd7;
    int         done_at = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: answers core_start with a single done pulse core_delay cycles later.
    always begin
        @(negedge clk);
        #2;
        core_done = (cyc == done_at);
        core_pred = core_pred_val;
        if (core_start && core_delay >= 0) done_at = cyc + core_delay;
    end

    // Output monitor: consumes the scoreboards whenever the DUT presents something.
    logic       prev_v = 1'b0;
    logic       prev_hs = 1'b0;
    logic [3:0] prev_p = '0;
    logic       prev_e = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (pix_we) begin
            if (wr_q.size() == 0) chk("unexpected_pix_we", 1, 0);
            else begin
                logic [ADDR_W+7:0] e;
                e = wr_q.pop_front();
                chk("pix_addr", pix_addr, e[ADDR_W+7:8]);
                chk("pix_data", pix_data, e[7:0]);
            end
        end
        if (core_start) begin
            starts++;
            chk("core_start_cycle", cyc, exp_start);
            exp_start = -1;
        end
        if (res_valid && !prev_v && exp_rise >= 0) begin
            chk("res_valid_rise_cycle", cyc, exp_rise);
            exp_rise = -1;
        end
        if (res_valid && prev_v && !prev_hs) begin
            chk("res_pred_stable", res_pred, prev_p);
            chk("res_err_stable", res_err, prev_e);
        end
        if (res_valid && res_ready) begin
            handshakes++;
            if (res_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                logic [4:0] r;
                r = res_q.pop_front();
                chk("res_pred", res_pred, r[4:1]);
                chk("res_err", res_err, r[0]);
            end
        end
        prev_v  = res_valid;
        prev_hs = res_valid && res_ready;
        prev_p  = res_pred;
        prev_e  = res_err;
    end

    // Reference outcome of a frame, decided when its final beat is accepted at cycle t.
    task automatic expect_frame_end(input int len, input int t, input bit expect_res);
        if (len == N_IN) begin
            exp_start = t + 2;
            exp_starts++;
            if (!expect_res) exp_rise = -1;
            else if (core_delay >= 0 && core_delay <= TIMEOUT - 1) begin
                exp_rise = t + 3 + core_delay;
                res_q.push_back({core_pred_val, 1'b0});
            end else begin
                exp_rise = t + 2 + TIMEOUT;
                res_q.push_back({4'hF, 1'b1});
            end
        end else begin
            exp_rise = t + 1;
            res_q.push_back({4'h0, 1'b1});
        end
    endtask

    task automatic check_reset_outputs();
        chk("reset_outputs",
            {s_ready, pix_we, pix_addr, pix_data, core_start, res_valid, res_pred, res_err, busy},
            {1'b1, 1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    endtask

    // Called at a negedge: one reset cycle, then the outputs must be back at reset values.
    task automatic pulse_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        #1;
        chk("s_ready_in_reset", s_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
    endtask

    task automatic send_frame(input int len, input bit bubbles, input bit rand_data,
                              input int abort_at, input bit expect_res);
        int i;
        int guard;
        logic [7:0] d;
        i = 0;
        guard = 0;
        while (i < len) begin
            @(negedge clk);
            if (i == abort_at) begin
                pulse_reset();
                return;
            end
            if (i == 10) chk("busy_mid_frame", busy, 1);
            if (bubbles && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
            end else begin
                d = rand_data ? 8'($urandom) : 8'(i);
                s_valid = 1'b1;
                s_data = d;
                s_last = (i == len - 1);
                if (s_ready) begin
                    if (i < N_IN) wr_q.push_back({ADDR_W'(i), d});
                    if (i == len - 1) expect_frame_end(len, cyc, expect_res);
                    i++;
                end
            end
            guard++;
            if (guard > len * 4 + 100) begin
                chk("beat_accept_timeout", i, len);
                s_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && (res_q.size() != 0 || wr_q.size() != 0); k++) @(negedge clk);
        chk("scoreboard_drained", res_q.size() + wr_q.size(), 0);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int s0;
        repeat (3) @(negedge clk);
        pulse_reset();

        // Nominal frame, ramp data, pred 7, done two cycles after start.
        core_delay = 2;
        core_pred_val = 4'd7;
        send_frame(N_IN, 0, 0, -1, 1);
        wait_idle();

        // Input bubbles plus a stalled result consumer.
        res_ready = 1'b0;
        core_delay = 3;
        core_pred_val = 4'($urandom_range(0, 9));
        send_frame(N_IN, 1, 1, -1, 1);
        for (int k = 0; k < 100 && !res_valid; k++) @(negedge clk);
        h0 = handshakes;
        repeat (10) @(negedge clk);
        chk("no_handshake_while_stalled", handshakes, h0);
        res_ready = 1'b1;
        wait_idle();
        chk("single_handshake", handshakes, h0 + 1);

        // Short frame, then a normal one.
        send_frame(100, 0, 1, -1, 1);
        wait_idle();
        core_pred_val = 4'($urandom_range(0, 9));
        send_frame(N_IN, 0, 1, -1, 1);
        wait_idle();

        // Long frame.
        send_frame(N_IN + 6, 1, 1, -1, 1);
        wait_idle();

        // Timeout, done on the last tick, done one tick too late.
        core_delay = -1;
        send_frame(N_IN, 0, 1, -1, 1);
        wait_idle();
        core_delay = TIMEOUT - 1;
        core_pred_val = 4'($urandom_range(0, 9));
        send_frame(N_IN, 0, 1, -1, 1);
        wait_idle();
        core_delay = TIMEOUT;
        send_frame(N_IN, 0, 1, -1, 1);
        wait_idle();

        // Reset at beat 400, then a full frame from address 0.
        core_delay = 2;
        send_frame(N_IN, 0, 1, 400, 1);
        chk("writes_before_abort_drained", wr_q.size(), 0);
        core_pred_val = 4'($urandom_range(0, 9));
        send_frame(N_IN, 0, 1, -1, 1);
        wait_idle();

        // Reset while waiting for the core; its late done must be ignored.
        core_delay = 6;
        s0 = starts;
        send_frame(N_IN, 0, 1, -1, 0);
        for (int k = 0; k < 20 && starts == s0; k++) @(negedge clk);
        chk("start_before_wait_reset", starts, s0 + 1);
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("no_result_after_wait_reset", {res_valid, busy}, 2'b00);
        end
        core_delay = 2;
        core_pred_val = 4'($urandom_range(0, 9));
        send_frame(N_IN, 0, 1, -1, 1);
        wait_idle();

        chk("core_start_count", starts, exp_starts);
        chk("pending_start", exp_start, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
